// File: rtl/mmio_map_pkg.sv
// MMIO map shared by the snapshot master and its users.
// Holds the coprocessor/DMEM space split, well-known selector numbers,
// the snapshot FSM state type and small address-forming helpers.
package mmio_map_pkg;

    // address[COPROC_SPACE_BIT]=1 selects coprocessor registers, 0 selects DMEM
    localparam int unsigned COPROC_SPACE_BIT = 12;

    localparam logic [4:0] PHYS_P1 = 5'd0;
    localparam logic [4:0] PHYS_P2 = 5'd1;
    localparam logic [4:0] CTRL_P1 = 5'd4;
    localparam logic [4:0] CTRL_P2 = 5'd5;
    localparam logic [4:0] COLL_P1 = 5'd12;
    localparam logic [4:0] COLL_P2 = 5'd13;
    localparam logic [4:0] ATK_P1  = 5'd16;
    localparam logic [4:0] ATK_P2  = 5'd17;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        READ,
        WRITE,
        FRAME,
        DONE
    } state_t;

    // Coprocessor register address for selector sel
    function automatic logic [12:0] coproc_addr(input logic [4:0] sel);
        logic [12:0] a;
        a = '0;
        a[COPROC_SPACE_BIT] = 1'b1;
        a[11:7] = sel;
        return a;
    endfunction

    // DMEM word address (coprocessor space bit forced low)
    function automatic logic [12:0] dmem_addr(input logic [11:0] word_addr);
        logic [12:0] a;
        a = {1'b0, word_addr};
        a[COPROC_SPACE_BIT] = 1'b0;
        return a;
    endfunction

endpackage

// File: rtl/mmio_snapshot_master_if.sv
// MMIO port bundle between the snapshot master and the arbitrated MMIO port.
//   bus_req  : master requests port ownership
//   bus_gnt  : arbiter grant
//   address  : 13-bit MMIO address
//   data_out : write data
//   wren     : write enable
//   data_in  : combinational read data
interface mmio_snapshot_master_if;
    logic        bus_req;
    logic        bus_gnt;
    logic [12:0] address;
    logic [31:0] data_out;
    logic        wren;
    logic [31:0] data_in;

    modport master (
        output bus_req, address, data_out, wren,
        input  bus_gnt, data_in
    );

    modport slave (
        input  bus_req, address, data_out, wren,
        output bus_gnt, data_in
    );
endinterface

// File: rtl/mask_scan.sv
// Lowest-set-bit finder for a 32-bit mask.
//   mask  : input mask
//   idx   : index of the lowest set bit (0 when mask is 0)
//   valid : 1 when any bit of mask is set
module mask_scan (
    input  logic [31:0] mask,
    output logic [4:0]  idx,
    output logic        valid
);
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (mask[i] && !valid) begin
                idx   = 5'(i);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mmio_snapshot_master.sv
// Snapshot master: on start, copies each selected coprocessor register into
// consecutive DMEM slots, optionally followed by a frame-counter word.
//   clock, reset : system clock, synchronous active-low reset
//   start        : snapshot request pulse (ignored while busy)
//   sel_mask     : selector bitmap, latched at start
//   base_addr    : DMEM destination base, 0 means DMEM_BASE_DEFAULT
//   bus          : MMIO master port (request/grant, address, data, wren)
//   busy, done   : snapshot in progress / one-cycle completion pulse
//   frame_count  : number of completed snapshots
module mmio_snapshot_master
    import mmio_map_pkg::*;
#(
    parameter logic [11:0] DMEM_BASE_DEFAULT = 12'h800,
    parameter bit          FRAME_WORD_EN     = 1'b1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [31:0]                   sel_mask,
    input  logic [11:0]                   base_addr,
    mmio_snapshot_master_if.master        bus,
    output logic                          busy,
    output logic                          done,
    output logic [31:0]                   frame_count
);

    state_t      state, state_nx;
    logic [31:0] mask_q;
    logic [11:0] base_q;
    logic [5:0]  slot_q;
    logic [31:0] word_q;
    logic [4:0]  sel_idx;
    logic        sel_valid;
    logic [31:0] mask_rest;
    logic [11:0] slot_addr;

    mask_scan u_scan (
        .mask  (mask_q),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    // Mask with the current (lowest) selector removed
    assign mask_rest = mask_q & (mask_q - 32'd1);
    // 12-bit add wraps the destination modulo 4096
    assign slot_addr = base_q + 12'(slot_q);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            mask_q      <= '0;
            base_q      <= '0;
            slot_q      <= '0;
            word_q      <= '0;
            frame_count <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q <= sel_mask;
                        base_q <= (base_addr == 12'd0) ? DMEM_BASE_DEFAULT : base_addr;
                        slot_q <= '0;
                    end
                end
                READ: begin
                    if (bus.bus_gnt) word_q <= bus.data_in;
                end
                WRITE: begin
                    if (bus.bus_gnt) begin
                        mask_q <= mask_rest;
                        slot_q <= slot_q + 6'd1;
                    end
                end
                DONE:    frame_count <= frame_count + 32'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx     = state;
        bus.bus_req  = 1'b0;
        bus.address  = '0;
        bus.data_out = '0;
        bus.wren     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = ARB;
            end
            ARB: begin
                busy        = 1'b1;
                bus.bus_req = 1'b1;
                if (bus.bus_gnt) begin
                    if (sel_valid)          state_nx = READ;
                    else if (FRAME_WORD_EN) state_nx = FRAME;
                    else                    state_nx = DONE;
                end
            end
            READ: begin
                busy        = 1'b1;
                bus.bus_req = 1'b1;
                if (bus.bus_gnt) begin
                    bus.address = coproc_addr(sel_idx);
                    state_nx    = WRITE;
                end
            end
            WRITE: begin
                busy        = 1'b1;
                bus.bus_req = 1'b1;
                if (bus.bus_gnt) begin
                    bus.address  = dmem_addr(slot_addr);
                    bus.data_out = word_q;
                    bus.wren     = 1'b1;
                    if (mask_rest != 32'd0) state_nx = READ;
                    else if (FRAME_WORD_EN) state_nx = FRAME;
                    else                    state_nx = DONE;
                end
            end
            FRAME: begin
                busy        = 1'b1;
                bus.bus_req = 1'b1;
                if (bus.bus_gnt) begin
                    // slot_q equals the popcount of the latched mask here
                    bus.address  = dmem_addr(slot_addr);
                    bus.data_out = frame_count + 32'd1;
                    bus.wren     = 1'b1;
                    state_nx     = DONE;
                end
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mmio_snapshot_master.sv
// Self-checking bench for mmio_snapshot_master against a behavioural model of
// the snapshot transfer (expected read/write sequence, latency, frame count).
module tb_mmio_snapshot_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] sel_mask;
    logic [11:0] base_addr;
    logic        busy;
    logic        done;
    logic [31:0] frame_count;

    mmio_snapshot_master_if bus ();

    mmio_snapshot_master #(
        .DMEM_BASE_DEFAULT (12'h800),
        .FRAME_WORD_EN     (1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .sel_mask    (sel_mask),
        .base_addr   (base_addr),
        .bus         (bus.master),
        .busy        (busy),
        .done        (done),
        .frame_count (frame_count)
    );

    always #5 clock = ~clock;

    // Coprocessor register file seen through the MMIO port
    logic [31:0] coproc_mem [0:31];
    assign bus.data_in = bus.address[12] ? coproc_mem[bus.address[11:7]] : 32'h0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [12:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [12:0] rd_addr [$];
    int          viol = 0;
    int          done_cnt = 0;
    logic [31:0] exp_frames = 0;

    always @(negedge clock) begin
        if (bus.bus_gnt && bus.wren) begin
            wr_addr.push_back(bus.address);
            wr_data.push_back(bus.data_out);
        end
        if (bus.bus_gnt && !bus.wren && bus.address[12])
            rd_addr.push_back(bus.address);
        if (!bus.bus_gnt && (bus.wren || bus.address != 13'd0 || bus.data_out != 32'd0))
            viol++;
        if (bus.wren && bus.address[12])
            viol++;
        if (done) done_cnt++;
    end

    task automatic fill_mem();
        for (int i = 0; i < 32; i++) coproc_mem[i] = $urandom;
    endtask

    // Run one snapshot and compare everything observed with the model.
    task automatic run_snap(input logic [31:0] m, input logic [11:0] b,
                            input int drop_at, input int drop_len,
                            input int arb_wait, input bit hold_start,
                            input string name);
        int exp_wa[$];
        logic [31:0] exp_wd[$];
        int exp_rd[$];
        int eb, k, pop, exp_lat, n, hold, rd, done0;
        bit drop_req;

        eb = (b == 12'd0) ? 32'h800 : int'(b);
        pop = $countones(m);
        k = 0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) begin
                exp_rd.push_back(32'h1000 + i * 128);
                exp_wa.push_back((eb + k) % 4096);
                exp_wd.push_back(coproc_mem[i]);
                k++;
            end
        end
        exp_wa.push_back((eb + pop) % 4096);
        exp_wd.push_back(exp_frames + 32'd1);
        exp_lat = 2 * pop + 3 + arb_wait + ((drop_len > 0 && drop_at < pop) ? drop_len : 0);

        wr_addr.delete(); wr_data.delete(); rd_addr.delete();
        done0 = done_cnt;
        hold = 0; rd = 0; drop_req = 1'b0;

        bus.bus_gnt = 1'b1;
        sel_mask = m; base_addr = b; start = 1'b1;
        @(posedge clock); #1; n = 1;
        if (!hold_start) start = 1'b0;
        // Input changes while busy must have no effect
        sel_mask = $urandom; base_addr = 12'($urandom);
        if (arb_wait > 0) begin bus.bus_gnt = 1'b0; hold = arb_wait; end
        while (n < 300) begin
            #1;
            if (done) break;
            if (bus.bus_gnt && bus.address[12]) begin
                rd++;
                if (rd == drop_at + 1 && drop_len > 0) drop_req = 1'b1;
            end
            @(posedge clock); #1; n++;
            if (drop_req) begin
                bus.bus_gnt = 1'b0; hold = drop_len; drop_req = 1'b0;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) bus.bus_gnt = 1'b1;
            end
        end
        bus.bus_gnt = 1'b1;

        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL %s timeout: done not seen after %0d cycles, required at %0d", name, n, exp_lat);
        end else if (n !== exp_lat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d required %0d", name, n, exp_lat);
        end

        @(posedge clock); #1;
        start = 1'b0;
        #1;
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s after_done: done=%b busy=%b required 0 0", name, done, busy);
        end

        exp_frames = exp_frames + 32'd1;
        tests_run++;
        if (frame_count !== exp_frames) begin
            tests_failed++;
            $display("FAIL %s frame_count: got %h required %h", name, frame_count, exp_frames);
        end
        tests_run++;
        if (done_cnt - done0 !== 1) begin
            tests_failed++;
            $display("FAIL %s done_pulses: got %0d required 1", name, done_cnt - done0);
        end

        tests_run++;
        if (rd_addr.size() !== exp_rd.size() || wr_addr.size() !== exp_wa.size()) begin
            tests_failed++;
            $display("FAIL %s counts: reads %0d writes %0d required %0d %0d", name,
                     rd_addr.size(), wr_addr.size(), exp_rd.size(), exp_wa.size());
        end else begin
            foreach (exp_rd[j]) begin
                tests_run++;
                if (rd_addr[j] !== 13'(exp_rd[j])) begin
                    tests_failed++;
                    $display("FAIL %s read[%0d]: got %h required %h", name, j, rd_addr[j], 13'(exp_rd[j]));
                end
            end
            foreach (exp_wa[j]) begin
                tests_run++;
                if (wr_addr[j] !== 13'(exp_wa[j]) || wr_data[j] !== exp_wd[j]) begin
                    tests_failed++;
                    $display("FAIL %s write[%0d]: got %h<=%h required %h<=%h", name, j,
                             wr_addr[j], wr_data[j], 13'(exp_wa[j]), exp_wd[j]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; sel_mask = '0; base_addr = '0; bus.bus_gnt = 1'b1;
        fill_mem();
        repeat (3) @(posedge clock);
        #1;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || frame_count !== 32'd0 || bus.bus_req !== 1'b0
            || bus.wren !== 1'b0 || bus.address !== 13'd0 || bus.data_out !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b done=%b fc=%h req=%b wren=%b addr=%h dout=%h required all 0",
                     busy, done, frame_count, bus.bus_req, bus.wren, bus.address, bus.data_out);
        end
        reset = 1'b1;
        exp_frames = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_two_slots();
        fill_mem();
        coproc_mem[0] = 32'h016000FA;
        coproc_mem[1] = 32'h02A900FA;
        run_snap(32'h3, 12'h800, -1, 0, 0, 1'b0, "two_slots");
    endtask

    task automatic test_wide_mask();
        fill_mem();
        run_snap(32'h00033033, 12'h000, -1, 0, 0, 1'b0, "wide_mask");
    endtask

    task automatic test_zero_mask();
        fill_mem();
        run_snap(32'h0, 12'h345, -1, 0, 0, 1'b0, "zero_mask");
    endtask

    task automatic test_wrap();
        fill_mem();
        run_snap(32'h3, 12'hFFF, -1, 0, 0, 1'b0, "wrap");
    endtask

    task automatic test_grant_drop();
        fill_mem();
        run_snap(32'h3, 12'h800, 0, 5, 0, 1'b0, "grant_drop");
        run_snap(32'h80000001, 12'h100, 1, 5, 2, 1'b0, "grant_drop_arb");
    endtask

    task automatic test_back_to_back();
        fill_mem();
        run_snap(32'h00010020, 12'h7F0, -1, 0, 0, 1'b1, "start_held");
    endtask

    task automatic test_reset_mid();
        int n, done0;
        fill_mem();
        bus.bus_gnt = 1'b1;
        sel_mask = 32'hF; base_addr = 12'h200; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        while (n < 20) begin
            #1;
            if (bus.address[12]) break;
            @(posedge clock); #1; n++;
        end
        tests_run++;
        if (!bus.address[12]) begin
            tests_failed++;
            $display("FAIL reset_mid no_read: address %h required coprocessor read", bus.address);
        end
        done0 = done_cnt;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        exp_frames = 0;
        tests_run++;
        if (bus.wren !== 1'b0 || busy !== 1'b0 || frame_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_mid state: wren=%b busy=%b fc=%h required 0 0 0", bus.wren, busy, frame_count);
        end
        repeat (10) @(posedge clock);
        #1;
        tests_run++;
        if (done_cnt !== done0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid aborted: done pulses %0d busy %b required 0 0", done_cnt - done0, busy);
        end
        run_snap(32'h5, 12'h000, -1, 0, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] m;
        logic [11:0] b;
        int pop, da, dl;
        for (int it = 0; it < 12; it++) begin
            fill_mem();
            m = (it % 3 == 0) ? $urandom : ($urandom & $urandom & $urandom);
            b = (it % 4 == 1) ? 12'h000 : 12'($urandom);
            pop = $countones(m);
            da = (pop > 0) ? $urandom_range(0, pop - 1) : -1;
            dl = (it % 2 == 0) ? $urandom_range(1, 4) : 0;
            run_snap(m, b, da, dl, $urandom_range(0, 3), 1'b0, $sformatf("random%0d", it));
        end
    endtask

    task automatic test_invariants();
        tests_run++;
        if (viol !== 0) begin
            tests_failed++;
            $display("FAIL bus_invariants: %0d violating cycles, required 0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_two_slots();
        test_wide_mask();
        test_zero_mask();
        test_wrap();
        test_grant_drop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mmio_snapshot_master.md
MMIO_SNAPSHOT_MASTER -- requirements
Module: mmio_snapshot_master

Interface
REQ-001 Parameter DMEM_BASE_DEFAULT, 12'h800: DMEM word address of slot 0 used when base_addr is 0.
REQ-002 Parameter FRAME_WORD_EN, 1: when 1, the frame-counter word is written after the slots.
REQ-003 clock  input  1  system clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  snapshot request pulse, e.g. a frame tick.
REQ-006 sel_mask  input  32  bit i set means selector i is captured.
REQ-007 base_addr  input  12  DMEM destination base; 0 selects DMEM_BASE_DEFAULT.
REQ-008 bus_req  output  1  requests ownership of the MMIO port.
REQ-009 bus_gnt  input  1  arbiter grant; the block drives bus outputs only while it is high.
REQ-010 address  output  13  MMIO address.
REQ-011 data_out  output  32  write data to the MMIO port.
REQ-012 wren  output  1  write enable.
REQ-013 data_in  input  32  combinational read data from the MMIO port.
REQ-014 busy  output  1  high from the accepted start until done.
REQ-015 done  output  1  one-cycle pulse when a snapshot completes.
REQ-016 frame_count  output  32  number of completed snapshots.

Function
REQ-017 States: IDLE, ARB, READ, WRITE, FRAME, DONE.
REQ-018 IDLE: if start=1, latch sel_mask and the effective base, then go to ARB with busy=1; otherwise start is ignored.
REQ-019 ARB: assert bus_req; when bus_gnt=1, go to READ at the lowest set latched bit; if the latched mask is 0, go to FRAME (or to DONE when FRAME_WORD_EN=0).
REQ-020 READ, one cycle: address = {1'b1, sel[4:0], 7'b0}, wren=0; capture data_in at the clock edge; go to WRITE.
REQ-021 WRITE, one cycle: address = {1'b0, (base+slot_idx) mod 4096}, data_out = captured word, wren=1; clear the latched bit; go to READ at the next set bit, else to FRAME or DONE.
REQ-022 slot_idx is the ordinal of the set bit within the latched mask (0,1,2,...), not the selector number, so slots are packed.
REQ-023 FRAME, one cycle: write frame_count+1 to (base+popcount) mod 4096, wren=1.
REQ-024 DONE: done=1, frame_count increments (wrapping FFFFFFFF->0), busy=0, bus_req=0, then go to IDLE.
REQ-025 Throughput is 2 cycles per selected slot, plus 1 for FRAME, plus 1 for DONE, plus grant wait.
REQ-026 bus_gnt low in READ/WRITE/FRAME: hold state, force wren=0 and address=0, keep bus_req=1; resume the same step when grant returns.
REQ-027 start during busy is ignored and is not queued; a start in the DONE cycle is also ignored.
REQ-028 sel_mask and base_addr changes during busy have no effect.
REQ-029 When bus_gnt=0, address, data_out and wren are all 0.
REQ-030 The block never writes with address[12]=1 and never reads with address[12]=0.

Reset
REQ-031 reset=0 at a posedge forces IDLE and all outputs to 0 on the next cycle, including frame_count.
REQ-032 Reset mid-snapshot aborts the snapshot: there is no done pulse and wren=0 from the next cycle.

Structure
REQ-033 mmio_map_pkg holds: COPROC_SPACE_BIT=12; selector constants PHYS_P1=0, PHYS_P2=1, CTRL_P1=4, CTRL_P2=5, COLL_P1=12, COLL_P2=13, ATK_P1=16, ATK_P2=17; the state enum.
REQ-034 One sub-module, mask_scan, provides combinational lowest-set-bit index plus a valid flag for a 32-bit mask.

Verification
REQ-035 Mask 0x00000003, base 0x800, pos1=0x016000FA, pos2=0x02A900FA, gnt=1 -> DMEM[0x800]=0x016000FA, DMEM[0x801]=0x02A900FA, DMEM[0x802]=1, done at cycle 7 after start.
REQ-036 Mask 0x00033033 -> 8 reads at 0x1000, 0x1080, 0x1200, 0x1280, 0x1600, 0x1680, 0x1800, 0x1880 in that order; writes to 0x800-0x807, then frame word at 0x808.
REQ-037 Mask 0 -> a single write of the frame word to the base, done 3 cycles after start.
REQ-038 Base 0xFFF, mask 0x3 -> writes to 0xFFF, then 0x000, then the frame word at 0x001.
REQ-039 bus_gnt dropped for 5 cycles during WRITE -> wren=0 throughout the drop, the same write is issued after regrant, and no data is lost.
REQ-040 reset=0 mid-READ -> no done pulse, frame_count=0, and a subsequent start completes normally.
